// File: rtl/gbcvt_pkg.sv
// gbcvt_pkg: shared gray decode, popcount and receiver state type for gray pointer links
package gbcvt_pkg;
  localparam int MAXW = 16;
  typedef enum logic [1:0] {FILL, PRIME, RUN} rx_state_e;
  function automatic logic [MAXW-1:0] gray2bin_f(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [4:0] popcount_f(input logic [MAXW-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAXW; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/gbcvt_sync.sv
// gbcvt_sync: STAGES-deep flop chain for a DW-wide bus, wire when STAGES is 0
module gbcvt_sync #(
  parameter int DW = 4,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_chain
    logic [DW-1:0] sr [STAGES];
    always_ff @(posedge clk) begin
      if (rst) for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      else begin
        sr[0] <= d;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[STAGES-1];
  end
endmodule

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: synchronise a gray pointer, decode it, report step and flag multi-bit jumps
module gray_ptr_rx
  import gbcvt_pkg::*;
#(
  parameter int DW = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  gray_in,
  input  logic           clr_err,
  output logic [DW-1:0]  bin_out,
  output logic           bin_vld,
  output logic [DW-1:0]  step,
  output logic           moved,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);
  logic [DW-1:0] g_sync, g_cur, g_prev, b_cur;
  logic [1:0] cnt;
  logic [4:0] hd;
  logic mv_now, err_now;
  rx_state_e state, state_nx;
  gbcvt_sync #(.DW(DW), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(gray_in),
    .q(g_sync)
  );
  assign b_cur = DW'(gray2bin_f(MAXW'(g_cur)));
  assign hd = popcount_f(MAXW'(g_cur ^ g_prev));
  assign mv_now = (state == RUN) && (hd == 5'd1);
  assign err_now = (state == RUN) && (hd > 5'd1);
  always_comb state_nx = (state == FILL) ? ((cnt == 2'(SYNC_STAGES)) ? PRIME : FILL) : RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == FILL) ? cnt + 2'd1 : '0;
    end
  end
  // bin_out always holds decode(g_prev), so it doubles as the previous binary value
  always_ff @(posedge clk) begin
    if (rst) begin
      g_cur <= '0;
      g_prev <= '0;
      bin_out <= '0;
      bin_vld <= 1'b0;
      step <= '0;
      moved <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      g_cur <= g_sync;
      if (state != FILL) begin
        g_prev <= g_cur;
        bin_out <= b_cur;
      end
      bin_vld <= bin_vld | (state == PRIME);
      moved <= mv_now;
      err <= err_now;
      step <= mv_now ? b_cur - bin_out : '0;
      err_cnt <= clr_err ? '0 : (err_now && err_cnt != '1) ? err_cnt + ECW'(1) : err_cnt;
    end
  end
endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx: random and directed stimulus checked against a sample-history reference model
module tb_gray_ptr_rx;
  localparam int DW = 4;
  logic clk = 1'b0, rst = 1'b1, clr_err = 1'b0;
  logic [3:0] gray_in = '0;
  logic [3:0] bin_out, step, s_bin, s_step;
  logic bin_vld, moved, err, s_vld, s_moved, s_err;
  logic [7:0] err_cnt;
  logic [1:0] s_cnt;
  int total = 0, bad = 0;
  logic [3:0] sq[$];
  int k = 0, ec = 0, ecs = 0;
  always #5 clk = ~clk;
  gray_ptr_rx #(.DW(4), .SYNC_STAGES(2), .ECW(8)) u_dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .bin_vld(bin_vld), .step(step), .moved(moved), .err(err), .err_cnt(err_cnt)
  );
  gray_ptr_rx #(.DW(4), .SYNC_STAGES(2), .ECW(2)) u_sat (
    .clk(clk), .rst(rst), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(s_bin), .bin_vld(s_vld), .step(s_step), .moved(s_moved), .err(s_err), .err_cnt(s_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at k=%0d", tag, got, exp, k);
    end
  endtask
  function automatic int g2b(input int g);
    int b = g;
    for (int sh = 1; sh < DW; sh = sh * 2) b = b ^ (b >> sh);
    return b;
  endfunction
  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction
  task automatic tick(input int g, input bit c, input bit r);
    int cur, prev, hd, e_bin, e_step, e_mv, e_err, e_vld;
    gray_in = 4'(g);
    clr_err = c;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      sq.delete();
    end else begin
      k++;
      sq.push_back(4'(g));
    end
    e_bin = 0; e_step = 0; e_mv = 0; e_err = 0; e_vld = 0;
    if (k == 4) begin
      e_bin = g2b(sq[0]);
      e_vld = 1;
    end else if (k >= 5) begin
      cur = sq[k-4];
      prev = sq[k-5];
      hd = $countones(cur ^ prev);
      e_vld = 1;
      e_bin = g2b(cur);
      e_mv = (hd == 1);
      e_err = (hd > 1);
      e_step = e_mv ? (g2b(cur) - g2b(prev) + 16) % 16 : 0;
    end
    if (r || c) begin
      ec = 0;
      ecs = 0;
    end else if (e_err) begin
      if (ec < 255) ec++;
      if (ecs < 3) ecs++;
    end
    check("bin_out", bin_out, e_bin);
    check("bin_vld", bin_vld, e_vld);
    check("step", step, e_step);
    check("moved", moved, e_mv);
    check("err", err, e_err);
    check("err_cnt", err_cnt, ec);
    check("sat_err_cnt", s_cnt, ecs);
    check("sat_bin_out", s_bin, e_bin);
  endtask
  initial begin
    int b, gc, r;
    tick(0, 0, 1);
    tick(0, 0, 1);
    repeat (4) tick(0, 0, 0);
    for (int i = 0; i < 16; i++) tick(b2g(i), 0, 0);
    tick(0, 0, 0);
    for (int i = 1; i <= 6; i++) tick(b2g(i), 0, 0);
    tick(7, 0, 0);
    tick(6, 0, 0);
    tick(2, 0, 0);
    repeat (10) tick(6, 0, 0);
    repeat (5) tick(0, 0, 0);
    tick(3, 0, 0);
    tick(2, 0, 0);
    repeat (5) tick(2, 0, 0);
    repeat (5) begin
      tick(0, 0, 0);
      tick(3, 0, 0);
    end
    repeat (4) tick(3, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    check("clr_wins_err", err, 1);
    check("clr_wins_cnt", s_cnt, 0);
    repeat (5) tick(0, 0, 0);
    for (int i = 0; i < 24; i++) tick(b2g(i % 16), 0, i == 12);
    b = 0;
    gc = 0;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) b = (b + 1) % 16;
      else if (r < 60) b = (b + 15) % 16;
      gc = (r >= 90) ? int'($urandom_range(0, 15)) : (r < 60) ? b2g(b) : gc;
      b = g2b(gc);
      tick(gc, ($urandom % 20) == 0, ($urandom % 100) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
